cam_pixel_capture: RTL and testbench
====================================

Name: cam_pixel_capture

Overview:
- Camera-side front end: samples the 8-bit camera bus and pairs bytes into RGB565 pixels.
- Writes each pixel into the async camera FIFO that the VGA display path drains.
- Runs entirely in the camera pixel-clock domain.
- Provides frame alignment, so the first FIFO word after frame start is always pixel (0,0) of a frame.

Parameters:
- H_ACTIVE, 640, pixels per line written to the FIFO; extra pixels on a line are dropped.
- V_ACTIVE, 480, lines per frame written to the FIFO; extra lines are dropped.
- SKIP_FRAMES, 2, whole frames discarded after reset while camera settings settle (range 0..15).

Ports:
- clk  input  1  camera pixel clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- cam_vsync  input  1  frame sync, active high during vertical blanking.
- cam_href  input  1  line valid, high while pixel bytes are on cam_data.
- cam_data  input  8  pixel byte; high byte (R5,G3 upper) first, low byte (G3 lower,B5) second.
- full_fifo  input  1  FIFO full flag, write side.
- wr_en  output  1  FIFO write strobe, one cycle per pixel.
- dout  output  16  RGB565 pixel {R[15:11],G[10:5],B[4:0]}; valid when wr_en=1.
- frame_done  output  1  one-cycle pulse at end of each captured frame.
- overflow  output  1  sticky: a pixel was dropped due to full_fifo in the current frame.

Behaviour:
- Reset (rst=1 at clk edge) is synchronous. All outputs return to 0; state=SKIP; skip counter, x/y counters and byte phase are cleared. This holds even mid-line; any partial pixel is discarded.
- cam_vsync and cam_href are registered once. Edges are detected on the registered copies.
- State SKIP:
  - Count rising edges of vsync.
  - When count reaches SKIP_FRAMES, go to WAIT_VS.
  - SKIP_FRAMES=0 goes to WAIT_VS on the first cycle after reset.
- State WAIT_VS: wait for vsync falling edge (frame start). Then clear x, y, phase and overflow, and go to CAPTURE.
- State CAPTURE, while href=1:
  - Phase 0: latch byte as hi; phase<=1.
  - Phase 1: form {hi,byte}; phase<=0.
  - If x<H_ACTIVE and y<V_ACTIVE and full_fifo=0: wr_en=1 and dout=pixel on the next clk (latency 1 cycle after the second byte is sampled).
  - If full_fifo=1 on a writable pixel: no write and overflow<=1.
  - x increments per completed pixel and saturates at H_ACTIVE.
- href falling edge: if x>0 then y<=y+1 (saturating at V_ACTIVE); x<=0; phase<=0. An odd trailing byte is discarded.
- vsync rising edge while in CAPTURE:
  - frame_done=1 for exactly one cycle; go to WAIT_VS.
  - The pulse is emitted even if fewer than V_ACTIVE lines arrived (short frame).
  - overflow holds its value until the next frame start clears it.
- Simultaneous vsync rise and href activity: vsync wins; the pixel in progress is discarded.
- full_fifo is sampled at the cycle the pixel completes. There is no retry or back-pressure to the camera.
- wr_en never asserts outside CAPTURE. Maximum one write per 2 clk.
- dout holds its last value when wr_en=0.
- Counter widths are clog2-sized from the parameters, minimum 10 bits for x and 9 bits for y.

Optional Feature:
- Macro: CAM_CAPTURE_TEST_PATTERN_EN.
- When defined, the captured pixel value is replaced by an 8-bar colour pattern: bar index = x*8/H_ACTIVE. The bars are white, yellow, cyan, green, magenta, red, blue, black (white=16'hFFFF, black=16'h0000, yellow=16'hFFE0, red=16'hF800, blue=16'h001F).
- Timing, wr_en, counters and overflow are unchanged; cam_data is ignored.
- When undefined, dout carries the camera bytes, and no pattern logic is synthesised.

Test Plan:
- Reset release with SKIP_FRAMES=2 and three 4x2-pixel synthetic frames (H_ACTIVE=4, V_ACTIVE=2) -> no wr_en during frames 1-2; frame 3 gives exactly 8 writes and frame_done pulses once.
- Bytes 8'hF8,8'h1F on one pixel -> dout=16'hF81F, wr_en high exactly 1 cycle, 1 clk after the low byte is sampled.
- Line of 6 pixels with H_ACTIVE=4, plus a 3rd line with V_ACTIVE=2 -> only 4 writes per line and none for line 3.
- full_fifo=1 during pixel 2 of the frame -> that pixel is not written and overflow=1 until the next vsync falling edge, then 0.
- rst pulsed mid-line after the high byte -> outputs 0 next cycle; state SKIP; no write for the orphan byte; normal capture after SKIP_FRAMES frames.
- With CAM_CAPTURE_TEST_PATTERN_EN, H_ACTIVE=640 -> pixel x=0 is 16'hFFFF, x=400 is 16'hF800, x=639 is 16'h0000, regardless of cam_data.

Source files
------------

// File: rtl/cam_pixel_capture.sv
// Camera capture front end: registers the 8-bit camera bus, pairs bytes into
// RGB565 pixels and writes them to the camera FIFO in frame-aligned order.
// Optional build macro: CAM_CAPTURE_TEST_PATTERN_EN replaces captured pixels
// with an 8-bar colour pattern (timing, counters and overflow unchanged).
module cam_pixel_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SKIP_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  input  logic        full_fifo,
  output logic        wr_en,
  output logic [15:0] dout,
  output logic        frame_done,
  output logic        overflow
);

  localparam int XW = ($clog2(H_ACTIVE + 1) > 10) ? $clog2(H_ACTIVE + 1) : 10;
  localparam int YW = ($clog2(V_ACTIVE + 1) > 9)  ? $clog2(V_ACTIVE + 1) : 9;

  typedef enum logic [1:0] {SKIP, WAIT_VS, CAPTURE} state_t;

  state_t        state, state_n;
  logic          vs_r, vs_q, hr_r, hr_q;
  logic [7:0]    d_r;
  logic [7:0]    hi_byte;
  logic          phase;
  logic [3:0]    skip_cnt;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          vs_rise, vs_fall, hr_fall;
  logic          in_window;
  logic [15:0]   pix_word;

`ifdef CAM_CAPTURE_TEST_PATTERN_EN
  function automatic logic [15:0] bar_colour(input logic [2:0] b);
    case (b)
      3'd0:    bar_colour = 16'hFFFF;
      3'd1:    bar_colour = 16'hFFE0;
      3'd2:    bar_colour = 16'h07FF;
      3'd3:    bar_colour = 16'h07E0;
      3'd4:    bar_colour = 16'hF81F;
      3'd5:    bar_colour = 16'hF800;
      3'd6:    bar_colour = 16'h001F;
      default: bar_colour = 16'h0000;
    endcase
  endfunction
`endif

  // Edge detection and pixel word selection on the registered camera signals
  always_comb begin
    vs_rise   = vs_r & ~vs_q;
    vs_fall   = ~vs_r & vs_q;
    hr_fall   = ~hr_r & hr_q;
    in_window = (x < XW'(H_ACTIVE)) && (y < YW'(V_ACTIVE));
`ifdef CAM_CAPTURE_TEST_PATTERN_EN
    pix_word  = bar_colour(3'((32'(x) * 32'd8) / 32'(H_ACTIVE)));
`else
    pix_word  = {hi_byte, d_r};
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= SKIP;
    else     state <= state_n;
  end

  // Next-state logic: settle frames, then align on frame start
  always_comb begin
    state_n = state;
    case (state)
      SKIP:    if (skip_cnt == 4'(SKIP_FRAMES)) state_n = WAIT_VS;
      WAIT_VS: if (vs_fall) state_n = CAPTURE;
      CAPTURE: if (vs_rise) state_n = WAIT_VS;
      default: state_n = SKIP;
    endcase
  end

  // Input sync, byte pairing, counters and FIFO write datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_r       <= 1'b0;
      vs_q       <= 1'b0;
      hr_r       <= 1'b0;
      hr_q       <= 1'b0;
      d_r        <= '0;
      hi_byte    <= '0;
      phase      <= 1'b0;
      skip_cnt   <= '0;
      x          <= '0;
      y          <= '0;
      wr_en      <= 1'b0;
      dout       <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      vs_r       <= cam_vsync;
      vs_q       <= vs_r;
      hr_r       <= cam_href;
      hr_q       <= hr_r;
      d_r        <= cam_data;
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      if (state == SKIP && skip_cnt != 4'(SKIP_FRAMES) && vs_rise)
        skip_cnt <= skip_cnt + 4'd1;
      if (state == WAIT_VS && vs_fall) begin
        x        <= '0;
        y        <= '0;
        phase    <= 1'b0;
        overflow <= 1'b0;
      end
      if (state == CAPTURE) begin
        // vsync rising has priority: any pixel in progress is abandoned
        if (vs_rise) begin
          frame_done <= 1'b1;
          phase      <= 1'b0;
        end else if (hr_r) begin
          if (!phase) begin
            hi_byte <= d_r;
            phase   <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (x < XW'(H_ACTIVE)) x <= x + 1'b1;
            if (in_window) begin
              if (full_fifo) begin
                overflow <= 1'b1;
              end else begin
                wr_en <= 1'b1;
                dout  <= pix_word;
              end
            end
          end
        end else if (hr_fall) begin
          if (x != '0 && y < YW'(V_ACTIVE)) y <= y + 1'b1;
          x     <= '0;
          phase <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Self-checking bench for cam_pixel_capture: randomized camera frames with a
// frame-level reference model that schedules expected FIFO writes, frame_done
// pulses and overflow changes per cycle, plus directed literal checks.
module tb_cam_pixel_capture;
  localparam int H = 4, V = 2, SKIP = 2, MAXC = 8192;

  logic clk = 1'b0;
  logic rst, cam_vsync, cam_href, full_fifo;
  logic [7:0] cam_data;
  logic wr_en, frame_done, overflow;
  logic [15:0] dout;

  always #5 clk = ~clk;

  cam_pixel_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(SKIP)) dut (
    .clk(clk), .rst(rst), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .full_fifo(full_fifo), .wr_en(wr_en), .dout(dout),
    .frame_done(frame_done), .overflow(overflow)
  );

  int checks = 0, failures = 0;
  int cyc = 0;
  bit chk_en = 0;
  bit exp_wr[MAXC];
  logic [15:0] exp_d[MAXC];
  bit exp_fd[MAXC], ov_set[MAXC], ov_clr[MAXC], rst_vis[MAXC];
  bit m_ov;
  logic [15:0] m_d;
  int wr_cnt = 0, fd_cnt = 0, last_wr_cyc = 0;
  logic [15:0] last_wr_d = '0;

  // Frame-level model state
  int mode, skip_cnt, mx, my, phase;
  logic [7:0] hi;
  bit pvs, phr, pend_v, pend_f;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] model_pixel(input logic [7:0] h, input logic [7:0] l, input int xp);
`ifdef CAM_CAPTURE_TEST_PATTERN_EN
    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    return bars[(xp * 8) / H];
`else
    return {h, l};
`endif
  endfunction

  // Per-cycle comparison of DUT outputs against the scheduled expectations
  always @(negedge clk) begin
    cyc++;
    if (cyc < MAXC) begin
      if (rst_vis[cyc]) begin
        m_ov = 0; m_d = '0; chk_en = 1;
      end
      if (chk_en) begin
        if (ov_clr[cyc]) m_ov = 0;
        if (ov_set[cyc]) m_ov = 1;
        check("wr_en", {31'd0, wr_en}, {31'd0, exp_wr[cyc]});
        check("frame_done", {31'd0, frame_done}, {31'd0, exp_fd[cyc]});
        check("overflow", {31'd0, overflow}, {31'd0, m_ov});
        if (exp_wr[cyc]) begin
          check("dout_write", {16'd0, dout}, {16'd0, exp_d[cyc]});
          m_d = exp_d[cyc];
        end else begin
          check("dout_hold", {16'd0, dout}, {16'd0, m_d});
        end
      end
      if (wr_en === 1'b1) begin
        wr_cnt++; last_wr_d = dout; last_wr_cyc = cyc;
      end
      if (frame_done === 1'b1) fd_cnt++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
    if (cyc >= MAXC - 4) begin
      $display("FAIL cycle_budget cyc=%0d actual=over required=under_%0d", cyc, MAXC - 4);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  task automatic do_reset(input int n);
    repeat (n) begin
      tick();
      rst = 1'b1;
      rst_vis[cyc + 1] = 1;
      for (int j = cyc + 1; j <= cyc + 3; j++) begin
        exp_wr[j] = 0; exp_fd[j] = 0; ov_set[j] = 0;
      end
      mode = (SKIP == 0) ? 1 : 0;
      skip_cnt = 0; mx = 0; my = 0; phase = 0;
      pvs = 0; phr = 0; pend_v = 0;
    end
  endtask

  // fmode: 0 random full, 1 force full, 2 force not full (for a pixel completing now)
  task automatic cyc_drive(input bit vs, input bit hr, input logic [7:0] d, input int fmode);
    bit f;
    int k;
    tick();
    k = cyc;
    rst = 1'b0;
    cam_vsync = vs;
    cam_href = hr;
    cam_data = d;
    full_fifo = pend_v ? pend_f : 1'($urandom_range(0, 1));
    pend_v = 0;
    if (vs && !pvs) begin
      if (mode == 0) begin
        skip_cnt++;
        if (skip_cnt >= SKIP) mode = 1;
      end else if (mode == 2) begin
        exp_fd[k + 2] = 1;
        mode = 1;
      end
    end else if (!vs && pvs) begin
      if (mode == 1) begin
        mode = 2; mx = 0; my = 0; phase = 0;
        ov_clr[k + 2] = 1;
      end
    end else if (mode == 2) begin
      if (hr) begin
        if (phase == 0) begin
          hi = d; phase = 1;
        end else begin
          phase = 0;
          if (mx < H && my < V) begin
            f = (fmode == 1) ? 1'b1 : (fmode == 2) ? 1'b0 : ($urandom_range(0, 5) == 0);
            pend_v = 1; pend_f = f;
            if (f) ov_set[k + 2] = 1;
            else begin
              exp_wr[k + 2] = 1;
              exp_d[k + 2] = model_pixel(hi, d, mx);
            end
          end
          if (mx < H) mx++;
        end
      end else if (phr) begin
        if (mx > 0 && my < V) my++;
        mx = 0; phase = 0;
      end
    end
    pvs = vs; phr = hr;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc_drive(0, 0, 8'($urandom), 0);
  endtask

  // full_pix >= 0 forces full on that pixel only; rnd selects random full and odd bytes
  task automatic line(input int npix, input int full_pix, input bit rnd, input bit odd);
    for (int p = 0; p < npix; p++) begin
      cyc_drive(0, 1, 8'($urandom), 0);
      cyc_drive(0, 1, 8'($urandom), rnd ? 0 : ((p == full_pix) ? 1 : 2));
    end
    if (odd) cyc_drive(0, 1, 8'($urandom), 0);
    idle(2 + $urandom_range(0, 2));
  endtask

  task automatic vs_pulse();
    repeat (3 + $urandom_range(0, 2)) cyc_drive(1, 0, 8'($urandom), 0);
    idle(3);
  endtask

  task automatic frame(input int nlines, input int npix, input int full_pix, input bit rnd);
    for (int l = 0; l < nlines; l++) begin
      if (rnd) line($urandom_range(1, 6), -1, 1, 1'($urandom_range(0, 1)));
      else     line(npix, (l == 0) ? full_pix : -1, 0, 0);
    end
    vs_pulse();
  endtask

  int w0, f0, lo_cyc;

  initial begin
    rst = 1'b1; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = '0; full_fifo = 1'b0;
    do_reset(3);
    tick();
    rst = 1'b0;
    check("reset_wr_en", {31'd0, wr_en}, 32'd0);
    check("reset_dout", {16'd0, dout}, 32'd0);
    check("reset_overflow", {31'd0, overflow}, 32'd0);
    check("reset_frame_done", {31'd0, frame_done}, 32'd0);
    idle(4);

    // Two settle frames produce nothing, third frame gives 8 writes and one pulse
    frame(2, 4, -1, 0);
    frame(2, 4, -1, 0);
    check("skip_no_writes", wr_cnt, 0);
    check("skip_no_done", fd_cnt, 0);
    frame(2, 4, -1, 0);
    check("frame3_writes", wr_cnt, 8);
    check("frame3_done", fd_cnt, 1);

    // Single pixel F8,1F
    cyc_drive(0, 1, 8'hF8, 0);
    cyc_drive(0, 1, 8'h1F, 2);
    lo_cyc = cyc;
    idle(4);
    check("pix_f81f_count", wr_cnt, 9);
`ifdef CAM_CAPTURE_TEST_PATTERN_EN
    check("pix_f81f_value", {16'd0, last_wr_d}, 32'h0000FFFF);
`else
    check("pix_f81f_value", {16'd0, last_wr_d}, 32'h0000F81F);
`endif
    check("pix_f81f_latency", last_wr_cyc, lo_cyc + 2);
    vs_pulse();

    // Oversized frame: 6-pixel lines, 3 lines, window 4x2
    w0 = wr_cnt; f0 = fd_cnt;
    frame(3, 6, -1, 0);
    check("crop_writes", wr_cnt - w0, 8);
    check("crop_done", fd_cnt - f0, 1);

    // FIFO full on pixel 2 of the frame
    w0 = wr_cnt;
    line(4, 1, 0, 0);
    line(4, -1, 0, 0);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    check("ovf_writes", wr_cnt - w0, 7);
    vs_pulse();
    check("ovf_cleared", {31'd0, overflow}, 32'd0);

    // Randomized frames with odd bytes, oversize lines and random full
    repeat (12) frame($urandom_range(1, 3), 0, -1, 1);

    // Reset mid-line after a high byte, then re-settle
    cyc_drive(0, 1, 8'hA5, 0);
    w0 = wr_cnt;
    do_reset(1);
    tick();
    rst = 1'b0;
    check("midrst_wr_en", {31'd0, wr_en}, 32'd0);
    check("midrst_dout", {16'd0, dout}, 32'd0);
    idle(4);
    check("midrst_no_orphan", wr_cnt - w0, 0);
    f0 = fd_cnt;
    frame(2, 4, -1, 0);
    frame(2, 4, -1, 0);
    check("midrst_skip", wr_cnt - w0, 0);
    frame(2, 4, -1, 0);
    check("midrst_capture", wr_cnt - w0, 8);
    check("midrst_done", fd_cnt - f0, 1);

    repeat (5) frame($urandom_range(1, 3), 0, -1, 1);
    idle(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
